// File: rtl/control_sequencer.sv
// Control sequencer: a Moore FSM that steps through the fetch phase (T0-T2),
// decodes the opcode class in T3 and runs the per-class execute phase (T4-T7).
// The class is latched in T3 so that later IR changes cannot disturb the
// instruction in flight.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR_Out,
  output logic        PC_Out,
  output logic        Zlow_Out,
  output logic        MDR_Out,
  output logic        C_Out,
  output logic        MAR_In,
  output logic        PC_In,
  output logic        MDR_In,
  output logic        IR_In,
  output logic        Y_In,
  output logic        Z_In,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        G_RA,
  output logic        G_RB,
  output logic        G_RC,
  output logic        R_In,
  output logic        R_Out,
  output logic        BA_Out,
  output logic [4:0]  ALU_op,
  output logic        Run
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_NOP, C_RTYPE, C_IMM, C_LD, C_ST, C_HALT
  } class_t;

  state_t     state_q, state_d;
  class_t     class_q, class_d;
  logic [4:0] alu_q, alu_d;
  class_t     cur_class;
  logic [4:0] opcode;

  // Only the opcode field matters to the sequencer.
  logic unused_ir_fields;
  assign unused_ir_fields = ^IR_Out[26:0];
  assign opcode           = IR_Out[31:27];

  function automatic class_t decode_class(input logic [4:0] op);
    class_t c;
    casez (op)
      5'b00???: c = C_RTYPE;
      5'b01000,
      5'b01001,
      5'b01010: c = C_IMM;
      5'b01011: c = C_LD;
      5'b01100: c = C_ST;
      5'b11011: c = C_HALT;
      default:  c = C_NOP;
    endcase
    return c;
  endfunction

  function automatic logic [4:0] decode_alu(input logic [4:0] op);
    logic [4:0] a;
    casez (op)
      5'b00???: a = {2'b00, op[2:0]};
      5'b01001: a = 5'b00010;
      5'b01010: a = 5'b00011;
      default:  a = 5'b00000;
    endcase
    return a;
  endfunction

  // In T3 the class comes straight from the freshly loaded IR; afterwards
  // the latched copy is used.
  assign cur_class = (state_q == S_T3) ? decode_class(opcode) : class_q;

  // State, latched class and latched ALU operation registers.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_RST;
      class_q <= C_NOP;
      alu_q   <= 5'b00000;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      alu_q   <= alu_d;
    end
  end

  // Next-state logic and T3 capture of the opcode class.
  always_comb begin
    state_d = state_q;
    class_d = class_q;
    alu_d   = alu_q;
    unique case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1:  state_d = S_T2;
      S_T2:  state_d = S_T3;
      S_T3: begin
        class_d = cur_class;
        alu_d   = decode_alu(opcode);
        case (cur_class)
          C_RTYPE, C_IMM, C_LD, C_ST: state_d = S_T4;
          C_HALT:                     state_d = S_HALT;
          default:                    state_d = S_T0;
        endcase
      end
      S_T4: state_d = S_T5;
      S_T5: state_d = (cur_class == C_LD || cur_class == C_ST) ? S_T6 : S_T0;
      S_T6: state_d = S_T7;
      S_T7: state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Moore output decode from the current state and opcode class.
  always_comb begin
    PC_Out   = 1'b0;
    Zlow_Out = 1'b0;
    MDR_Out  = 1'b0;
    C_Out    = 1'b0;
    MAR_In   = 1'b0;
    PC_In    = 1'b0;
    MDR_In   = 1'b0;
    IR_In    = 1'b0;
    Y_In     = 1'b0;
    Z_In     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Write    = 1'b0;
    G_RA     = 1'b0;
    G_RB     = 1'b0;
    G_RC     = 1'b0;
    R_In     = 1'b0;
    R_Out    = 1'b0;
    BA_Out   = 1'b0;
    ALU_op   = 5'b00000;
    Run      = (state_q != S_RST) && (state_q != S_HALT);
    unique case (state_q)
      S_T0: begin
        PC_Out = 1'b1;
        MAR_In = 1'b1;
        IncPC  = 1'b1;
        Z_In   = 1'b1;
      end
      S_T1: begin
        Zlow_Out = 1'b1;
        PC_In    = 1'b1;
        Read     = 1'b1;
        MDR_In   = 1'b1;
      end
      S_T2: begin
        MDR_Out = 1'b1;
        IR_In   = 1'b1;
      end
      S_T3: begin
        case (cur_class)
          C_RTYPE, C_IMM: begin
            G_RB  = 1'b1;
            R_Out = 1'b1;
            Y_In  = 1'b1;
          end
          C_LD, C_ST: begin
            G_RB   = 1'b1;
            BA_Out = 1'b1;
            Y_In   = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        Z_In   = 1'b1;
        ALU_op = alu_q;
        if (cur_class == C_RTYPE) begin
          G_RC  = 1'b1;
          R_Out = 1'b1;
        end else begin
          C_Out = 1'b1;
        end
      end
      S_T5: begin
        Zlow_Out = 1'b1;
        if (cur_class == C_LD || cur_class == C_ST) begin
          MAR_In = 1'b1;
        end else begin
          G_RA = 1'b1;
          R_In = 1'b1;
        end
      end
      S_T6: begin
        MDR_In = 1'b1;
        if (cur_class == C_LD) begin
          Read = 1'b1;
        end else begin
          G_RA  = 1'b1;
          R_Out = 1'b1;
        end
      end
      S_T7: begin
        if (cur_class == C_LD) begin
          MDR_Out = 1'b1;
          G_RA    = 1'b1;
          R_In    = 1'b1;
        end else begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
